// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings and the in-flight stage record used by the interlock controller.
package hazard_stall_ctrl_pkg;

  localparam int REC_REG_W = 5;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  localparam logic [REC_REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 valid;
    logic [REC_REG_W-1:0] dest;
    logic [1:0]           memtoreg;
  } stage_rec_t;

  function automatic stage_rec_t rec_invalid();
    stage_rec_t r;
    r.valid    = 1'b0;
    r.dest     = REG_ZERO;
    r.memtoreg = MTR_ALU;
    return r;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_match.sv
// Compares one in-flight stage record against one ID source operand and
// classifies the hit by the kind of value the producer will write back.
module hazard_match
  import hazard_stall_ctrl_pkg::*;
(
  input  stage_rec_t           rec,
  input  logic [REC_REG_W-1:0] r,
  input  logic                 used,
  output logic                 hit_alu,
  output logic                 hit_mem,
  output logic                 hit_pc4
);

  logic hit;

  // $0 is never a real dependency, so a zero destination can never match.
  assign hit     = rec.valid && used && (rec.dest != REG_ZERO) && (rec.dest == r);
  assign hit_alu = hit && (rec.memtoreg == MTR_ALU);
  assign hit_mem = hit && (rec.memtoreg == MTR_MEM);
  assign hit_pc4 = hit && (rec.memtoreg == MTR_PC4);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Interlock controller beside ID: shadows the EX/MEM writers and raises
// stall/bubble/flush for hazards the forwarding network cannot resolve.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_early,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [1:0]       id_memtoreg,
  input  logic             id_redirect,
  output logic             stall_pc,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_rec_t       ex_rec_reg, ex_rec_next;
  stage_rec_t       mem_rec_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  // Index layout: 0 = EX/rs, 1 = EX/rt, 2 = MEM/rs, 3 = MEM/rt.
  logic [3:0] hit_alu, hit_mem, hit_pc4;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_match
      hazard_match u_match (
        .rec     ((gi < 2) ? ex_rec_reg : mem_rec_reg),
        .r       ((gi % 2 == 0) ? id_rs : id_rt),
        .used    ((gi % 2 == 0) ? id_use_rs : id_use_rt),
        .hit_alu (hit_alu[gi]),
        .hit_mem (hit_mem[gi]),
        .hit_pc4 (hit_pc4[gi])
      );
    end
  endgenerate

  // Link values (PC_4) are always available on the forward path, so they never interlock.
  logic unused_hits;
  assign unused_hits = |{hit_pc4, hit_alu[3:2]};

  logic load_use, early_op, stall;

  always_comb begin
    load_use = id_valid && !id_early && (hit_mem[0] || hit_mem[1]);
    early_op = id_valid && id_early &&
               (hit_alu[0] || hit_alu[1] || hit_mem[0] || hit_mem[1] ||
                hit_mem[2] || hit_mem[3]);
    stall    = load_use || early_op;
  end

  always_comb begin
    ex_rec_next = rec_invalid();
    if (!stall) begin
      ex_rec_next.valid    = id_valid;
      ex_rec_next.dest     = id_wr_reg;
      ex_rec_next.memtoreg = id_memtoreg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_rec_reg    <= rec_invalid();
      mem_rec_reg   <= rec_invalid();
      stall_cnt_reg <= '0;
    end else if (!freeze) begin
      mem_rec_reg <= ex_rec_reg;
      ex_rec_reg  <= ex_rec_next;
      if (stall) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  // Freeze overrides everything; a redirect waits until its operands are ready.
  assign stall_pc   = freeze || stall;
  assign bubble_ex  = stall && !freeze;
  assign flush_ifid = id_valid && id_redirect && !stall && !freeze;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the live outputs.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic        id_early;
  logic [4:0]  id_wr_reg;
  logic [1:0]  id_memtoreg;
  logic        id_redirect;
  logic        stall_pc, bubble_ex, flush_ifid;
  logic [31:0] stall_cnt;

  hazard_stall_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .freeze      (freeze),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_early    (id_early),
    .id_wr_reg   (id_wr_reg),
    .id_memtoreg (id_memtoreg),
    .id_redirect (id_redirect),
    .stall_pc    (stall_pc),
    .bubble_ex   (bubble_ex),
    .flush_ifid  (flush_ifid),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sp;
    logic        bx;
    logic        fl;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string n, input string field,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", n, field, act, req);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("vec %-10s stall_pc=%0b bubble_ex=%0b flush_ifid=%0b stall_cnt=%0d",
               e.name, stall_pc, bubble_ex, flush_ifid, stall_cnt);
      check(e.name, "stall_pc",   {31'd0, stall_pc},   {31'd0, e.sp});
      check(e.name, "bubble_ex",  {31'd0, bubble_ex},  {31'd0, e.bx});
      check(e.name, "flush_ifid", {31'd0, flush_ifid}, {31'd0, e.fl});
      check(e.name, "stall_cnt",  stall_cnt,           e.cnt);
    end
  end

  // Apply one cycle of ID-stage inputs and queue the outputs expected in that cycle.
  task automatic vec(input string name, input logic rst, input logic frz, input logic vld,
                     input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                     input logic early, input logic [4:0] wr, input logic [1:0] mtr,
                     input logic redir, input logic esp, input logic ebx, input logic efl,
                     input logic [31:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    freeze      = frz;
    id_valid    = vld;
    id_rs       = rs;
    id_use_rs   = urs;
    id_rt       = rt;
    id_use_rt   = urt;
    id_early    = early;
    id_wr_reg   = wr;
    id_memtoreg = mtr;
    id_redirect = redir;
    e.name = name; e.sp = esp; e.bx = ebx; e.fl = efl; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  task automatic nop(input string name, input logic [31:0] ecnt);
    vec(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ecnt);
  endtask

  initial begin
    reset = 1'b0; freeze = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_early = 1'b0; id_wr_reg = '0; id_memtoreg = '0; id_redirect = 1'b0;
    repeat (2) @(posedge clk);

    //   name         rst frz vld rs  urs rt urt erl wr  mtr rd  sp bx fl cnt
    vec("reset",      0,  0,  0,  0,  0,  0, 0,  0,  0,  0,  0,  0, 0, 0, 0);
    // load-use: lw $8 ; add rs=$8
    vec("lu_lw",      1,  0,  1,  0,  0,  0, 0,  0,  8,  1,  0,  0, 0, 0, 0);
    vec("lu_add1",    1,  0,  1,  8,  1,  2, 1,  0,  10, 0,  0,  1, 1, 0, 0);
    vec("lu_add2",    1,  0,  1,  8,  1,  2, 1,  0,  10, 0,  0,  0, 0, 0, 1);
    nop("lu_nop", 1);
    // branch behind ALU op
    vec("ba_add",     1,  0,  1,  0,  0,  0, 0,  0,  9,  0,  0,  0, 0, 0, 1);
    vec("ba_beq1",    1,  0,  1,  9,  1,  0, 1,  1,  0,  0,  1,  1, 1, 0, 1);
    vec("ba_beq2",    1,  0,  1,  9,  1,  0, 1,  1,  0,  0,  1,  0, 0, 1, 2);
    nop("ba_nop", 2);
    // branch behind load, dependency on rt
    vec("bl_lw",      1,  0,  1,  0,  0,  0, 0,  0,  9,  1,  0,  0, 0, 0, 2);
    vec("bl_beq1",    1,  0,  1,  1,  1,  9, 1,  1,  0,  0,  1,  1, 1, 0, 2);
    vec("bl_beq2",    1,  0,  1,  1,  1,  9, 1,  1,  0,  0,  1,  1, 1, 0, 3);
    vec("bl_beq3",    1,  0,  1,  1,  1,  9, 1,  1,  0,  0,  1,  0, 0, 1, 4);
    nop("bl_nop", 4);
    // PC_4 producer: jal then jr $31 (EX, then MEM)
    vec("pc_jal",     1,  0,  1,  0,  0,  0, 0,  0,  31, 2,  1,  0, 0, 1, 4);
    vec("pc_jr1",     1,  0,  1,  31, 1,  0, 0,  1,  0,  0,  1,  0, 0, 1, 4);
    vec("pc_jr2",     1,  0,  1,  31, 1,  0, 0,  1,  0,  0,  1,  0, 0, 1, 4);
    nop("pc_nop", 4);
    // $0 destination and unused operand
    vec("z_lw0",      1,  0,  1,  0,  0,  0, 0,  0,  0,  1,  0,  0, 0, 0, 4);
    vec("z_add0",     1,  0,  1,  0,  1,  0, 1,  0,  0,  0,  0,  0, 0, 0, 4);
    vec("u_lw8",      1,  0,  1,  0,  0,  0, 0,  0,  8,  1,  0,  0, 0, 0, 4);
    vec("u_add",      1,  0,  1,  3,  1,  8, 0,  0,  0,  0,  0,  0, 0, 0, 4);
    nop("u_nop", 4);
    // freeze with a load-use pending
    vec("f_lw",       1,  0,  1,  0,  0,  0, 0,  0,  8,  1,  0,  0, 0, 0, 4);
    vec("f_frz1",     1,  1,  1,  8,  1,  0, 0,  0,  10, 0,  0,  1, 0, 0, 4);
    vec("f_frz2",     1,  1,  1,  8,  1,  0, 0,  0,  10, 0,  0,  1, 0, 0, 4);
    vec("f_frz3",     1,  1,  1,  8,  1,  0, 0,  0,  10, 0,  0,  1, 0, 0, 4);
    vec("f_rel",      1,  0,  1,  8,  1,  0, 0,  0,  10, 0,  0,  1, 1, 0, 4);
    vec("f_add",      1,  0,  1,  8,  1,  0, 0,  0,  10, 0,  0,  0, 0, 0, 5);
    nop("f_nop", 5);
    // reset on the first edge of a two-cycle branch stall
    vec("r_lw",       1,  0,  1,  0,  0,  0, 0,  0,  9,  1,  0,  0, 0, 0, 5);
    vec("r_beq_rst",  0,  0,  1,  9,  1,  0, 0,  1,  0,  0,  1,  1, 1, 0, 5);
    vec("r_beq",      1,  0,  1,  9,  1,  0, 0,  1,  0,  0,  1,  0, 0, 1, 0);
    nop("r_nop", 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline interlock controller: issues stall, bubble and flush for the 5-stage MIPS pipeline in the cases the forwarding muxes cannot cover.
- Sits beside the ID stage and tracks in-flight writers in EX and MEM with its own shadow records.
- Covers load-use hazards, ID-stage branch/jr operand hazards, control flush on taken branch/jump, and a global freeze for a memory wait.
- Counts stall cycles for performance debug.

Parameters:
- REG_W, 5, register index width
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- freeze  in  1  memory wait; holds the whole pipeline
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_W  source register indices
- id_use_rs, id_use_rt  in  1  source is read
- id_early  in  1  instruction consumes its operands in ID (beq/bne/jr/jalr)
- id_wr_reg  in  REG_W  resolved destination after RegDst; 0 = no write
- id_memtoreg  in  2  0 ALU, 1 memory, 2 PC_4
- id_redirect  in  1  branch taken or jump resolved in ID
- stall_pc  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- flush_ifid  out  1  squash IF/ID
- stall_cnt  out  CNT_W  cycles with stall_pc=1

Behaviour:
- Reset (reset=0 at a clk edge): EX/MEM records invalid, dest=0; stall_cnt=0. Outputs are combinational and are 0 whenever records are invalid and id_valid=0.
- Records: ex_rec and mem_rec, each {valid, dest, memtoreg}. The register is ignored when dest=0.
- Each clk edge with freeze=0 and stall=0: mem_rec<=ex_rec; ex_rec<={id_valid, id_wr_reg, id_memtoreg}.
- With stall=1 and freeze=0: mem_rec<=ex_rec; ex_rec<=invalid (bubble).
- With freeze=1: both records hold.
- match(rec, r): rec.valid, rec.dest!=0, rec.dest==r, and r is used.
- Load-use stall: id_valid, id_early=0, match(ex_rec) on rs or rt, and ex_rec.memtoreg==1.
- Early-operand stall: id_valid, id_early=1, and either:
  - match(ex_rec) with ex_rec.memtoreg in {0,1}, or
  - match(mem_rec) with mem_rec.memtoreg==1.
  - PC_4 producers never stall; they are forwarded from EX/MEM.
- stall = load-use OR early-operand.
- stall_pc=stall; bubble_ex=stall.
- flush_ifid = id_valid AND id_redirect AND NOT stall. Stall beats flush: a redirect is acted on only in the cycle its operands are ready.
- freeze=1 forces stall_pc=1, bubble_ex=0, flush_ifid=0. The frozen cycle does not count.
- Latency: a hazard created by the instruction in ID at edge N is visible in the outputs in cycle N+1. A load-use stall lasts 1 cycle. A branch behind an ALU op lasts 1 cycle; a branch behind a load lasts 2 cycles.
- stall_cnt increments on each clk edge where stall=1 and freeze=0. It wraps at 2^CNT_W−1 → 0.
- Reset mid-stall: records are cleared, so stall deasserts in the next cycle.

Decomposition:
- Shared package holds:
  - MemToReg encodings MTR_ALU=0, MTR_MEM=1, MTR_PC4=2.
  - REG_ZERO=0.
  - The stage record typedef {valid, dest, memtoreg}.
- One sub-module, hazard_match: combinational record-versus-operand compare returning hit_alu, hit_mem, hit_pc4. Instantiated for ex_rec and mem_rec against rs and rt.

Test Plan:
- Load-use: lw $8 (dest 8, mtr 1) then add using rs=8, id_early=0 → stall_pc=bubble_ex=1 for exactly 1 cycle, then 0; stall_cnt=1.
- Branch after ALU op: add $9 then beq rs=9 (id_early=1) → 1 stall cycle. Branch after load: lw $9 then beq rs=9 → 2 stall cycles; flush_ifid=1 only in the cycle after the stall ends, with id_redirect=1.
- PC_4 producer: jal (dest 31, mtr 2) then jr rs=31 → stall=0, flush_ifid=1 immediately.
- $0 and unused operands: lw to dest 0 then add rs=0; also rt=8 with id_use_rt=0 after lw $8 → no stall.
- Freeze: lw $8 with freeze held 3 cycles before the consumer → records hold, stall_pc=1, bubble_ex=0, stall_cnt unchanged; after release the normal 1-cycle load-use stall occurs.
- Reset during a 2-cycle branch stall (reset=0 on the 1st stall edge) → records cleared, next cycle stall=0, stall_cnt=0.
